uart_imem_loader: RTL and testbench



---
 rtl/uart_imem_loader_if.sv | 44 ++++
 rtl/uart_imem_loader.sv | 197 +++++++++++++++++++
 tb/tb_uart_imem_loader.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the UART image loader.
// LOADER_ECHO_EN adds the transmit echo channel and its overflow flag.
interface uart_imem_loader_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  i_rx_valid;
  logic [7:0]            i_rx_byte;
  logic                  o_imem_we;
  logic [ADDR_WIDTH-1:0] o_imem_addr;
  logic [BUS_WIDTH-1:0]  o_imem_wdata;
  logic                  o_cpu_hold;
  logic                  o_load_done;
  logic                  o_load_err;
  logic [15:0]           o_word_count;
`ifdef LOADER_ECHO_EN
  logic                  i_tx_ready;
  logic                  o_tx_valid;
  logic [7:0]            o_tx_byte;
  logic                  o_echo_ovf;

  modport slave (
    input  i_rx_valid, i_rx_byte, i_tx_ready,
    output o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_hold, o_load_done,
           o_load_err, o_word_count, o_tx_valid, o_tx_byte, o_echo_ovf
  );
  modport master (
    output i_rx_valid, i_rx_byte, i_tx_ready,
    input  o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_hold, o_load_done,
           o_load_err, o_word_count, o_tx_valid, o_tx_byte, o_echo_ovf
  );
`else
  modport slave (
    input  i_rx_valid, i_rx_byte,
    output o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_hold, o_load_done,
           o_load_err, o_word_count
  );
  modport master (
    output i_rx_valid, i_rx_byte,
    input  o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_hold, o_load_done,
           o_load_err, o_word_count
  );
`endif
endinterface

// File: rtl/uart_imem_loader.sv
// Assembles a UART program-image frame (A5, LEN, LE words, XOR checksum) into imem writes
// and holds the CPU until a clean load. Optional echo channel: define LOADER_ECHO_EN.
//
// state  | meaning
// S_IDLE | waiting for sync byte 0xA5
// S_LEN0 | expecting low byte of word count
// S_LEN1 | expecting high byte of word count, range check
// S_DATA | collecting 4*N data bytes, writing each completed word
// S_CSUM | expecting XOR checksum byte
// S_DONE | one-cycle success state, load_done pulses
// S_ERR  | failed frame, sticky until the next 0xA5
module uart_imem_loader #(
  parameter int BUS_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int HOLD_AT_RESET  = 1
) (
  input logic             clk,
  input logic             rst,
  uart_imem_loader_if.slave bus
);
  localparam int              TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]     MAX_WORDS = 17'(1 << ADDR_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

  state_t                r_state;
  logic [TMO_W-1:0]      r_tmo;
  logic [7:0]            r_len_lo;
  logic [15:0]           r_len;
  logic [1:0]            r_idx;
  logic [23:0]           r_word;
  logic [7:0]            r_csum;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_imem_we;
  logic [ADDR_WIDTH-1:0] r_imem_addr;
  logic [BUS_WIDTH-1:0]  r_imem_wdata;
  logic                  r_cpu_hold;
  logic                  r_load_done;
  logic                  r_load_err;
  logic [15:0]           r_word_count;

  logic        w_rx_valid;
  logic [7:0]  w_byte;
  logic        w_start;
  logic [15:0] w_len;
  logic        w_len_big;
  logic        w_last_word;

  assign w_rx_valid  = bus.i_rx_valid;
  assign w_byte      = bus.i_rx_byte;
  assign w_start     = w_rx_valid && (w_byte == 8'hA5);
  assign w_len       = {w_byte, r_len_lo};
  assign w_len_big   = {1'b0, w_len} > MAX_WORDS;
  assign w_last_word = 16'(r_word_count + 16'd1) == r_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tmo        <= TMO_LOAD;
      r_len_lo     <= 8'h00;
      r_len        <= 16'h0000;
      r_idx        <= 2'd0;
      r_word       <= 24'h000000;
      r_csum       <= 8'h00;
      r_addr       <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_hold   <= (HOLD_AT_RESET != 0);
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_word_count <= 16'h0000;
    end else begin
      r_imem_we   <= 1'b0;
      r_load_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          // a byte landing in DONE is handled exactly as in IDLE
          if (r_state == S_DONE) r_state <= S_IDLE;
          if (w_start) begin
            r_state      <= S_LEN0;
            r_tmo        <= TMO_LOAD;
            r_load_err   <= 1'b0;
            r_word_count <= 16'h0000;
            r_csum       <= 8'h00;
            r_idx        <= 2'd0;
            r_addr       <= '0;
            r_imem_addr  <= '0;
            r_cpu_hold   <= 1'b1;
          end
        end
        default: begin
          if (w_rx_valid) begin
            r_tmo <= TMO_LOAD;
            case (r_state)
              S_LEN0: begin
                r_len_lo <= w_byte;
                r_state  <= S_LEN1;
              end
              S_LEN1: begin
                r_len <= w_len;
                if (w_len_big) begin
                  r_state    <= S_ERR;
                  r_load_err <= 1'b1;
                end else if (w_len == 16'd0) begin
                  r_state <= S_CSUM;
                end else begin
                  r_state <= S_DATA;
                end
              end
              S_DATA: begin
                r_csum <= r_csum ^ w_byte;
                r_idx  <= r_idx + 2'd1;
                case (r_idx)
                  2'd0: r_word[7:0]   <= w_byte;
                  2'd1: r_word[15:8]  <= w_byte;
                  2'd2: r_word[23:16] <= w_byte;
                  default: begin
                    r_imem_we    <= 1'b1;
                    r_imem_addr  <= r_addr;
                    r_imem_wdata <= {w_byte, r_word};
                    r_addr       <= r_addr + ADDR_WIDTH'(1);
                    r_word_count <= r_word_count + 16'd1;
                    if (w_last_word) r_state <= S_CSUM;
                  end
                endcase
              end
              S_CSUM: begin
                if (w_byte == r_csum) begin
                  r_state     <= S_DONE;
                  r_load_done <= 1'b1;
                  r_cpu_hold  <= 1'b0;
                end else begin
                  r_state    <= S_ERR;
                  r_load_err <= 1'b1;
                end
              end
              default: ;
            endcase
          end else if (r_tmo == '0) begin
            r_state    <= S_ERR;
            r_load_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo - TMO_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.o_imem_we    = r_imem_we;
  assign bus.o_imem_addr  = r_imem_addr;
  assign bus.o_imem_wdata = r_imem_wdata;
  assign bus.o_cpu_hold   = r_cpu_hold;
  assign bus.o_load_done  = r_load_done;
  assign bus.o_load_err   = r_load_err;
  assign bus.o_word_count = r_word_count;

`ifdef LOADER_ECHO_EN
  logic       r_tx_valid;
  logic [7:0] r_tx_byte;
  logic       r_echo_ovf;
  logic       r_was_err;
  logic       w_notify;
  logic       w_busy;
  logic [7:0] w_code;

  // ACK/NAK is queued in the first cycle of DONE/ERR, after the checksum byte's own echo
  assign w_notify = (r_state == S_DONE) || ((r_state == S_ERR) && !r_was_err);
  assign w_code   = (r_state == S_DONE) ? 8'h06 : 8'h15;
  assign w_busy   = r_tx_valid && !bus.i_tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_valid <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_echo_ovf <= 1'b0;
      r_was_err  <= 1'b0;
    end else begin
      r_was_err <= (r_state == S_ERR);
      if (w_rx_valid || w_notify) begin
        r_tx_valid <= 1'b1;
        r_tx_byte  <= w_rx_valid ? w_byte : w_code;
        if (w_busy || (w_rx_valid && w_notify)) r_echo_ovf <= 1'b1;
      end else if (bus.i_tx_ready) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  assign bus.o_tx_valid = r_tx_valid;
  assign bus.o_tx_byte  = r_tx_byte;
  assign bus.o_echo_ovf = r_echo_ovf;
`endif
endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader: frame-position reference model checked every cycle,
// directed literal cases and randomized frames; echo cases compiled when LOADER_ECHO_EN is set.
module tb_uart_imem_loader;
  localparam int AW  = 10;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_imem_loader_if #(.BUS_WIDTH(32), .ADDR_WIDTH(AW)) bus_if ();

  uart_imem_loader #(
    .BUS_WIDTH(32), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO), .HOLD_AT_RESET(1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: position of the next byte within the frame (-1 = not in a frame)
  int          m_pos, m_n, m_idle, m_wc, m_addr;
  logic [7:0]  m_csum;
  logic [31:0] m_word, m_wdata;
  logic        m_we, m_done, m_err, m_hold;

  always @(posedge clk) begin
    logic [7:0] b;
    int k;
    b = bus_if.i_rx_byte;
    m_we = 1'b0;
    m_done = 1'b0;
    if (rst) begin
      m_pos = -1; m_err = 1'b0; m_wc = 0; m_hold = 1'b1; m_addr = 0; m_wdata = 0; m_idle = 0;
    end else if (m_pos < 0) begin
      if (bus_if.i_rx_valid && b == 8'hA5) begin
        m_pos = 0; m_err = 1'b0; m_wc = 0; m_csum = 8'h00; m_hold = 1'b1; m_idle = 0; m_addr = 0;
      end
    end else if (bus_if.i_rx_valid) begin
      m_idle = 0;
      if (m_pos == 0) begin
        m_n = int'(b); m_pos = 1;
      end else if (m_pos == 1) begin
        m_n = m_n + int'(b) * 256;
        if (m_n > (1 << AW)) begin m_err = 1'b1; m_pos = -1; end
        else m_pos = 2;
      end else if (m_pos < 2 + 4 * m_n) begin
        k = (m_pos - 2) % 4;
        m_word[8*k +: 8] = b;
        m_csum = m_csum ^ b;
        if (k == 3) begin
          m_we = 1'b1; m_addr = (m_pos - 2) / 4; m_wdata = m_word; m_wc++;
        end
        m_pos++;
      end else begin
        if (b == m_csum) begin m_done = 1'b1; m_hold = 1'b0; end
        else m_err = 1'b1;
        m_pos = -1;
      end
    end else if (m_idle == TMO - 1) begin
      m_err = 1'b1; m_pos = -1;
    end else begin
      m_idle++;
    end
  end

  int          wa_q[$];
  logic [31:0] wd_q[$];
  int          n_done = 0;
`ifdef LOADER_ECHO_EN
  logic [7:0]  tx_q[$];
`endif

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_we", 32'(bus_if.o_imem_we), 32'(m_we));
      if (m_we) begin
        chk("imem_addr", 32'(bus_if.o_imem_addr), 32'(m_addr));
        chk("imem_wdata", bus_if.o_imem_wdata, m_wdata);
      end
      chk("load_done", 32'(bus_if.o_load_done), 32'(m_done));
      chk("load_err", 32'(bus_if.o_load_err), 32'(m_err));
      chk("cpu_hold", 32'(bus_if.o_cpu_hold), 32'(m_hold));
      chk("word_count", 32'(bus_if.o_word_count), 32'(m_wc));
      if (bus_if.o_imem_we) begin
        wa_q.push_back(int'(bus_if.o_imem_addr));
        wd_q.push_back(bus_if.o_imem_wdata);
      end
      if (bus_if.o_load_done) n_done++;
`ifdef LOADER_ECHO_EN
      if (bus_if.o_tx_valid && bus_if.i_tx_ready) tx_q.push_back(bus_if.o_tx_byte);
`endif
    end
  end

  logic [7:0] frm[$];

  task automatic cyc(input logic v, input logic [7:0] b);
    @(negedge clk);
    bus_if.i_rx_valid = v;
    bus_if.i_rx_byte  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00);
  endtask

  task automatic send(input int gap_max, input int nbytes);
    for (int i = 0; i < nbytes && i < frm.size(); i++) begin
      cyc(1'b1, frm[i]);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
    cyc(1'b0, 8'h00);
  endtask

  task automatic build(input int n, input bit bad);
    logic [7:0] cs, b;
    logic [31:0] nn;
    nn = n;
    cs = 8'h00;
    frm = {};
    frm.push_back(8'hA5);
    frm.push_back(nn[7:0]);
    frm.push_back(nn[15:8]);
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      frm.push_back(b);
      cs = cs ^ b;
    end
    frm.push_back(bad ? (cs ^ 8'h5A) : cs);
  endtask

  task automatic clear_obs();
    wa_q = {};
    wd_q = {};
    n_done = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"}, 32'(bus_if.o_imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(bus_if.o_imem_addr), 32'd0);
    chk({tag, "_wdata"}, bus_if.o_imem_wdata, 32'd0);
    chk({tag, "_done"}, 32'(bus_if.o_load_done), 32'd0);
    chk({tag, "_err"}, 32'(bus_if.o_load_err), 32'd0);
    chk({tag, "_wc"}, 32'(bus_if.o_word_count), 32'd0);
    chk({tag, "_hold"}, 32'(bus_if.o_cpu_hold), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.i_rx_valid = 1'b0;
    bus_if.i_rx_byte  = 8'h00;
`ifdef LOADER_ECHO_EN
    bus_if.i_tx_ready = 1'b1;
`endif
    rst = 1'b1;
    idle(3);
    chk_reset_vals("reset");
    rst = 1'b0;
    chk_en = 1'b1;

    // garbage in IDLE
    clear_obs();
    cyc(1'b1, 8'h00); cyc(1'b1, 8'hFF); idle(3);
    chk("garbage_writes", 32'(wa_q.size()), 32'd0);
    chk("garbage_hold", 32'(bus_if.o_cpu_hold), 32'd1);
    chk("garbage_err", 32'(bus_if.o_load_err), 32'd0);

    // normal load
    clear_obs();
    frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send(2, 99); idle(3);
    chk("normal_nwr", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      chk("normal_a0", 32'(wa_q[0]), 32'd0);
      chk("normal_d0", wd_q[0], 32'h00000013);
      chk("normal_a1", 32'(wa_q[1]), 32'd1);
      chk("normal_d1", wd_q[1], 32'h00100093);
    end
    chk("normal_done", 32'(n_done), 32'd1);
    chk("normal_hold", 32'(bus_if.o_cpu_hold), 32'd0);
    chk("normal_wc", 32'(bus_if.o_word_count), 32'd2);
    chk("normal_err", 32'(bus_if.o_load_err), 32'd0);

    // bad checksum, then a good frame
    clear_obs();
    frm[11] = 8'h91;
    send(1, 99); idle(3);
    chk("badcs_nwr", 32'(wa_q.size()), 32'd2);
    chk("badcs_err", 32'(bus_if.o_load_err), 32'd1);
    chk("badcs_hold", 32'(bus_if.o_cpu_hold), 32'd1);
    chk("badcs_done", 32'(n_done), 32'd0);
    clear_obs();
    frm[11] = 8'h90;
    send(0, 99); idle(3);
    chk("recover_err", 32'(bus_if.o_load_err), 32'd0);
    chk("recover_done", 32'(n_done), 32'd1);
    chk("recover_hold", 32'(bus_if.o_cpu_hold), 32'd0);

    // zero length
    clear_obs();
    frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send(0, 99); idle(3);
    chk("zero_done", 32'(n_done), 32'd1);
    chk("zero_nwr", 32'(wa_q.size()), 32'd0);
    chk("zero_wc", 32'(bus_if.o_word_count), 32'd0);

    // oversize: 1025 words rejected right after LEN_HI
    clear_obs();
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h01); cyc(1'b1, 8'h04); cyc(1'b0, 8'h00);
    chk("oversize_err", 32'(bus_if.o_load_err), 32'd1);
    idle(3);
    chk("oversize_nwr", 32'(wa_q.size()), 32'd0);

    // exactly 1024 words is accepted (no error after LEN_HI); let it time out afterwards
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h00); cyc(1'b1, 8'h04); cyc(1'b0, 8'h00);
    chk("max_len_err", 32'(bus_if.o_load_err), 32'd0);
    idle(20);

    // timeout: error exactly on the 16th idle cycle
    clear_obs();
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h01); cyc(1'b1, 8'h00); cyc(1'b1, 8'h13); cyc(1'b0, 8'h00);
    repeat (15) @(negedge clk);
    chk("tmo_before", 32'(bus_if.o_load_err), 32'd0);
    @(negedge clk);
    chk("tmo_at16", 32'(bus_if.o_load_err), 32'd1);
    chk("tmo_hold", 32'(bus_if.o_cpu_hold), 32'd1);
    chk("tmo_nwr", 32'(wa_q.size()), 32'd0);

    // reset after the 2nd data byte, then a back-to-back frame
    clear_obs();
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h01); cyc(1'b1, 8'h00); cyc(1'b1, 8'h11); cyc(1'b1, 8'h22);
    cyc(1'b0, 8'h00);
    rst = 1'b1;
    cyc(1'b0, 8'h00);
    chk_reset_vals("midrst");
    rst = 1'b0;
    frm = '{8'hA5, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67, 8'h45, 8'h23, 8'h01, 8'h22};
    send(0, 99); idle(3);
    chk("b2b_nwr", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      chk("b2b_d0", wd_q[0], 32'hDEADBEEF);
      chk("b2b_a1", 32'(wa_q[1]), 32'd1);
      chk("b2b_d1", wd_q[1], 32'h01234567);
    end
    chk("b2b_done", 32'(n_done), 32'd1);

    // randomized frames against the model
    for (int t = 0; t < 60; t++) begin
      int kind;
      kind = $urandom_range(0, 9);
      case (kind)
        0: begin
          for (int i = 0; i < 3; i++) cyc(1'b1, 8'($urandom));
          cyc(1'b0, 8'h00);
        end
        1: begin
          frm = '{8'hA5, 8'($urandom), 8'($urandom_range(4, 255))};
          send(1, 99);
        end
        2: begin
          build($urandom_range(1, 3), 1'b0);
          send(1, $urandom_range(1, frm.size() - 1));
          idle(TMO + 2);
        end
        3: begin
          build($urandom_range(1, 3), 1'b0);
          send(1, $urandom_range(1, frm.size() - 1));
          rst = 1'b1;
          cyc(1'b0, 8'h00);
          rst = 1'b0;
        end
        default: begin
          build($urandom_range(0, 5), ($urandom_range(0, 4) == 0));
          send(2, 99);
        end
      endcase
      idle(2);
    end

`ifdef LOADER_ECHO_EN
    rst = 1'b1;
    cyc(1'b0, 8'h00);
    rst = 1'b0;
    bus_if.i_tx_ready = 1'b1;
    idle(2);
    tx_q = {};
    frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send(0, 99); idle(4);
    chk("echo_len", 32'(tx_q.size()), 32'd13);
    if (tx_q.size() == 13) begin
      for (int i = 0; i < 12; i++) chk("echo_byte", 32'(tx_q[i]), 32'(frm[i]));
      chk("echo_ack", 32'(tx_q[12]), 32'h06);
    end
    chk("echo_noovf", 32'(bus_if.o_echo_ovf), 32'd0);
    bus_if.i_tx_ready = 1'b0;
    cyc(1'b1, 8'h31); cyc(1'b1, 8'h32); cyc(1'b0, 8'h00);
    chk("echo_ovf", 32'(bus_if.o_echo_ovf), 32'd1);
    chk("echo_last", 32'(bus_if.o_tx_byte), 32'h32);
    chk("echo_valid", 32'(bus_if.o_tx_valid), 32'd1);
    bus_if.i_tx_ready = 1'b1;
    idle(2);
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
